// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : SPI target. Oversamples SCLK/SS_n/MOSI with the system clock,
//            deserialises MOSI into right-justified words and serialises a
//            transmit holding register onto MISO. Character length, bit
//            order and receive/transmit SCLK edges are configurable per frame.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int SYNC_STAGES = 2,   // must be >= 2
    parameter int MAX_LEN     = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_sclk,
    input  logic               i_ss_n,
    input  logic               i_mosi,
    output logic               o_miso,
    output logic               o_miso_oe,
    input  logic [4:0]         i_len,
    input  logic               i_lsb,
    input  logic               i_rx_negedge,
    input  logic               i_tx_negedge,
    input  logic [MAX_LEN-1:0] i_tx_data,
    input  logic               i_tx_valid,
    output logic               o_tx_ready,
    output logic [MAX_LEN-1:0] o_rx_data,
    output logic               o_rx_valid,
    output logic               o_tx_underrun,
    output logic               o_busy
);

    localparam int c_CW = $clog2(MAX_LEN + 1);   // bit counter width
    localparam int c_IW = $clog2(MAX_LEN);       // bit index width

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_ACTIVE = 1'b1;

    // Synchroniser chains and one extra stage for edge detection
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_ss_d;

    // Latched frame configuration
    logic [4:0]             r_len;
    logic                   r_lsb;
    logic                   r_rx_neg;
    logic                   r_tx_neg;

    // Datapath and control state
    logic [0:0]             r_state;
    logic [MAX_LEN-1:0]     r_hold;
    logic                   r_hold_full;
    logic [MAX_LEN-1:0]     r_tx_sr;
    logic [MAX_LEN-1:0]     r_rx_sr;
    logic [c_CW-1:0]        r_cnt;
    logic                   r_sampled;
    logic                   r_word_done;
    logic [MAX_LEN-1:0]     r_rx_data;
    logic                   r_rx_valid;
    logic                   r_underrun;

    logic                   w_s_sclk;
    logic                   w_s_ss_n;
    logic                   w_s_mosi;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_ss_fall;
    logic                   w_ss_rise;
    logic                   w_rx_edge;
    logic                   w_tx_edge;
    logic                   w_active;
    logic [4:0]             w_cfg_len;
    logic                   w_cfg_lsb;
    logic [c_CW-1:0]        w_len_bits;
    logic [c_CW-1:0]        w_pad;
    logic [c_CW-1:0]        w_cnt_inc;
    logic                   w_word_end;
    logic                   w_rx_act;
    logic                   w_tx_act;
    logic                   w_load;
    logic                   w_tx_shift;
    logic                   w_underrun;
    logic [MAX_LEN-1:0]     w_load_src;
    logic [MAX_LEN-1:0]     w_load_word;
    logic [MAX_LEN-1:0]     w_rx_next;

    assign w_s_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_s_ss_n    = r_ss_sync[SYNC_STAGES-1];
    assign w_s_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_s_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_s_sclk & r_sclk_d;
    assign w_ss_fall   = ~w_s_ss_n & r_ss_d;
    assign w_ss_rise   = w_s_ss_n & ~r_ss_d;
    assign w_rx_edge   = r_rx_neg ? w_sclk_fall : w_sclk_rise;
    assign w_tx_edge   = r_tx_neg ? w_sclk_fall : w_sclk_rise;
    assign w_active    = (r_state == c_ST_ACTIVE);

    // The load at frame start must already use the configuration being latched
    assign w_cfg_len   = w_ss_fall ? i_len : r_len;
    assign w_cfg_lsb   = w_ss_fall ? i_lsb : r_lsb;
    assign w_len_bits  = (w_cfg_len == 5'd0) ? c_CW'(MAX_LEN) : c_CW'(w_cfg_len);
    assign w_pad       = c_CW'(MAX_LEN) - w_len_bits;

    assign w_cnt_inc   = r_cnt + c_CW'(1);
    assign w_rx_act    = w_active & ~w_ss_rise & w_rx_edge;
    assign w_word_end  = w_rx_act & (w_cnt_inc == w_len_bits);
    // A transmit edge only counts once the current bit has been sampled
    assign w_tx_act    = w_active & ~w_ss_rise & w_tx_edge & (r_sampled | w_rx_edge);
    assign w_load      = (~w_active & w_ss_fall) | (w_tx_act & r_word_done);
    assign w_tx_shift  = w_tx_act & ~r_word_done;

    assign w_load_src  = r_hold_full ? r_hold : (i_tx_valid ? i_tx_data : '0);
    assign w_underrun  = ~r_hold_full & ~i_tx_valid;
    // MSB-first words are left-justified so the first bit is always the top bit
    assign w_load_word = w_cfg_lsb ? w_load_src : (w_load_src << w_pad);

    // Next receive shift value: MSB-first shifts in at bit 0, LSB-first writes bit r_cnt
    always_comb begin
        w_rx_next = r_rx_sr;
        if (r_lsb) begin
            w_rx_next[r_cnt[c_IW-1:0]] = w_s_mosi;
        end else begin
            w_rx_next = {r_rx_sr[MAX_LEN-2:0], w_s_mosi};
        end
    end

    // Pad synchronisers; SS_n idles high so reset does not fake a frame start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_d    <= w_s_sclk;
            r_ss_d      <= w_s_ss_n;
        end
    end

    // Frame configuration captured at the start of each frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len    <= 5'd0;
            r_lsb    <= 1'b0;
            r_rx_neg <= 1'b0;
            r_tx_neg <= 1'b0;
        end else if (w_ss_fall) begin
            r_len    <= i_len;
            r_lsb    <= i_lsb;
            r_rx_neg <= i_rx_negedge;
            r_tx_neg <= i_tx_negedge;
        end
    end

    // Transmit holding register and transmit shift register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_tx_sr     <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_load) begin
                r_hold_full <= 1'b0;
                r_tx_sr     <= w_load_word;
                r_underrun  <= w_underrun;
            end else begin
                if (i_tx_valid && !r_hold_full) begin
                    r_hold      <= i_tx_data;
                    r_hold_full <= 1'b1;
                end
                if (w_tx_shift) begin
                    r_tx_sr <= r_lsb ? (r_tx_sr >> 1) : (r_tx_sr << 1);
                end
            end
        end
    end

    // IDLE/ACTIVE control, receive assembly and word completion
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_rx_sr     <= '0;
            r_sampled   <= 1'b0;
            r_word_done <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt       <= '0;
                    r_rx_sr     <= '0;
                    r_sampled   <= 1'b0;
                    r_word_done <= 1'b0;
                    if (w_ss_fall) begin
                        r_state <= c_ST_ACTIVE;
                    end
                end
                c_ST_ACTIVE: begin
                    if (w_ss_rise) begin
                        // Abort or normal end: partial word is dropped
                        r_state     <= c_ST_IDLE;
                        r_cnt       <= '0;
                        r_rx_sr     <= '0;
                        r_sampled   <= 1'b0;
                        r_word_done <= 1'b0;
                    end else begin
                        if (w_tx_act) begin
                            r_sampled <= 1'b0;
                        end else if (w_rx_act) begin
                            r_sampled <= 1'b1;
                        end
                        if (w_word_end) begin
                            r_word_done <= 1'b1;
                        end else if (w_tx_act && r_word_done) begin
                            r_word_done <= 1'b0;
                        end
                        if (w_rx_act) begin
                            if (w_word_end) begin
                                r_rx_data  <= w_rx_next;
                                r_rx_valid <= 1'b1;
                                r_cnt      <= '0;
                                r_rx_sr    <= '0;
                            end else begin
                                r_cnt   <= w_cnt_inc;
                                r_rx_sr <= w_rx_next;
                            end
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign o_miso        = w_active & (r_lsb ? r_tx_sr[0] : r_tx_sr[MAX_LEN-1]);
    assign o_miso_oe     = w_active;
    assign o_busy        = w_active;
    assign o_tx_ready    = ~r_hold_full;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_tx_underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Purpose  : Self-checking bench for spi_slave. A master model drives SCLK,
//            SS_n and MOSI, a feeder supplies transmit words, and a monitor
//            pops expected receive words whenever o_rx_valid pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int SYNC = 2;

    logic        clk;
    logic        rst_n;
    logic        sclk;
    logic        ss_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [4:0]  len;
    logic        lsb;
    logic        rx_neg;
    logic        tx_neg;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        tx_underrun;
    logic        busy;

    spi_slave #(.SYNC_STAGES(SYNC), .MAX_LEN(32)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sclk        (sclk),
        .i_ss_n        (ss_n),
        .i_mosi        (mosi),
        .o_miso        (miso),
        .o_miso_oe     (miso_oe),
        .i_len         (len),
        .i_lsb         (lsb),
        .i_rx_negedge  (rx_neg),
        .i_tx_negedge  (tx_neg),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .o_rx_data     (rx_data),
        .o_rx_valid    (rx_valid),
        .o_tx_underrun (tx_underrun),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          under_cnt = 0;
    int          byp_req  = 0;
    int          byp_done = 0;
    logic [31:0] byp_word = '0;
    logic [31:0] feed_q[$];    // words waiting for the feeder
    logic [31:0] avail_q[$];   // model: words the slave will load, in order
    logic [31:0] exp_rx[$];    // scoreboard: expected receive words
    logic [31:0] rxw[4];       // words the master sends in the next frame

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic feed(input logic [31:0] w);
        feed_q.push_back(w);
        avail_q.push_back(w);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},     {31'd0, miso},        32'd0);
        check({tag, "_miso_oe"},  {31'd0, miso_oe},     32'd0);
        check({tag, "_tx_ready"}, {31'd0, tx_ready},    32'd1);
        check({tag, "_rx_data"},  rx_data,              32'd0);
        check({tag, "_rx_valid"}, {31'd0, rx_valid},    32'd0);
        check({tag, "_underrun"}, {31'd0, tx_underrun}, 32'd0);
        check({tag, "_busy"},     {31'd0, busy},        32'd0);
    endtask

    // Feeder: single driver of the transmit handshake, one-cycle valid pulses
    initial begin
        tx_valid = 1'b0;
        tx_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_valid) begin
                tx_valid = 1'b0;
            end else if (byp_req != byp_done) begin
                byp_done++;
                tx_data  = byp_word;
                tx_valid = 1'b1;
            end else if (feed_q.size() > 0 && tx_ready) begin
                tx_data  = feed_q.pop_front();
                tx_valid = 1'b1;
            end
        end
    end

    // Monitor: compares every received word against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rx_valid) begin
                    if (exp_rx.size() == 0) begin
                        check("rx_unexpected", {31'd0, rx_valid}, 32'd0);
                    end else begin
                        check("rx_data", rx_data, exp_rx.pop_front());
                    end
                end
                if (tx_underrun) under_cnt++;
            end
        end
    end

    // Watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // One SS_n frame of nwords words; abort_bits>0 raises SS_n after that many samples
    task automatic run_frame(input bit f_lsb, input bit f_rxn, input bit f_txn, input bit idle,
                             input logic [4:0] f_len, input int nwords, input int half,
                             input int abort_bits, input bit bypass);
        int          bits;
        logic [31:0] mask;
        bit          rx_odd;
        bit          trailing;
        bit          aborted;
        int          nloads;
        int          exp_under;
        int          under0;
        int          nrx;
        int          lat;
        logic [31:0] cap;
        logic [31:0] exp_tx[5];
        bit          rxe;
        int          k;
        int          pos;
        logic [31:0] cur;

        bits     = (f_len == 5'd0) ? 32 : int'(f_len);
        mask     = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        // rx edges fall on odd toggles when the idle level precedes the sampling edge
        rx_odd   = (f_rxn == idle);
        // a transmit edge after the final sample triggers one extra load
        trailing = (f_rxn != f_txn) && rx_odd;
        aborted  = (abort_bits > 0);
        nloads   = aborted ? 1 : nwords + int'(trailing);
        exp_under = 0;
        for (int i = 0; i < nloads; i++) begin
            if (i == 0 && bypass) begin
                exp_tx[i] = byp_word;
            end else if (avail_q.size() > 0) begin
                exp_tx[i] = avail_q.pop_front();
            end else begin
                exp_tx[i] = 32'd0;
                exp_under++;
            end
        end
        if (!aborted) begin
            for (int w = 0; w < nwords; w++) exp_rx.push_back(rxw[w] & mask);
        end

        @(negedge clk);
        len = f_len; lsb = f_lsb; rx_neg = f_rxn; tx_neg = f_txn; sclk = idle;
        repeat (4) @(negedge clk);
        under0 = under_cnt;
        ss_n = 1'b0;
        if (bypass) begin
            @(posedge clk);
            @(posedge clk);
            byp_req++;
        end
        repeat (half) @(negedge clk);
        if (bypass) check("bypass_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("busy_active", {30'd0, busy, miso_oe}, 32'd3);

        nrx = 0;
        for (int w = 0; w < nwords; w++) begin
            cap = '0;
            cur = rxw[w];
            for (int t = 1; t <= 2 * bits; t++) begin
                if (aborted && nrx >= abort_bits) break;
                rxe = (((t % 2) == 1) == rx_odd);
                k   = (t - 1) / 2;
                pos = f_lsb ? k : bits - 1 - k;
                if (rxe) mosi = cur[pos];
                repeat (half) @(negedge clk);
                if (rxe) begin
                    cap[pos] = miso;
                    nrx++;
                end
                sclk = ~sclk;
            end
            if (!aborted) check("miso_word", cap, exp_tx[w] & mask);
        end

        repeat (half) @(negedge clk);
        ss_n = 1'b1;
        lat = 0;
        while (busy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("busy_fall_latency", {31'd0, (lat <= SYNC + 2)}, 32'd1);
        check("idle_miso", {30'd0, miso_oe, miso}, 32'd0);
        repeat (4) @(negedge clk);
        check("underrun_count", under_cnt - under0, exp_under);
        check("rx_drained", exp_rx.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] m;
        rst_n = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        len = 5'd8; lsb = 1'b0; rx_neg = 1'b0; tx_neg = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic MSB-first word; a spare word covers the trailing reload
        feed(32'h0000_00A5);
        feed($urandom);
        rxw[0] = 32'h0000_003C;
        run_frame(1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1, 6, 0, 1'b0);

        // Full-width LSB-first word, both edges rising
        feed(32'h8000_0001);
        rxw[0] = 32'hDEAD_BEEF;
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1, 6, 0, 1'b0);

        // Back-to-back 16-bit words with refill
        for (int i = 0; i < 4; i++) feed($urandom);
        for (int i = 0; i < 3; i++) rxw[i] = $urandom;
        run_frame(1'b0, 1'b0, 1'b1, 1'b0, 5'd16, 3, 6, 0, 1'b0);

        // Back-to-back without refill: second word underruns
        feed($urandom);
        rxw[0] = $urandom; rxw[1] = $urandom;
        run_frame(1'b0, 1'b0, 1'b1, 1'b1, 5'd16, 2, 6, 0, 1'b0);

        // Mid-word abort after 5 of 8 bits, then a clean frame
        feed($urandom);
        rxw[0] = $urandom;
        run_frame(1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1, 6, 5, 1'b0);
        feed($urandom);
        rxw[0] = $urandom;
        run_frame(1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1, 6, 0, 1'b0);

        // Bypass load at frame start with an empty holding register
        byp_word = $urandom;
        rxw[0] = $urandom;
        run_frame(1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1, 6, 0, 1'b1);

        // Mode sweep: every edge combination and both idle levels
        for (int i = 0; i < 8; i++) begin
            m = i;
            feed($urandom);
            rxw[0] = $urandom;
            run_frame(1'($urandom_range(0, 1)), m[0], m[1], m[2],
                      5'($urandom_range(0, 31)), 1, 5, 0, 1'b0);
        end

        // Asynchronous reset in the middle of a frame
        feed($urandom);
        @(negedge clk);
        len = 5'd8; lsb = 1'b0; rx_neg = 1'b0; tx_neg = 1'b1; sclk = 1'b0;
        repeat (4) @(negedge clk);
        ss_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int t = 0; t < 5; t++) begin
            mosi = 1'($urandom_range(0, 1));
            repeat (6) @(negedge clk);
            sclk = ~sclk;
        end
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        avail_q.delete();
        exp_rx.delete();
        sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Recovery frame after reset
        feed($urandom);
        rxw[0] = $urandom;
        run_frame(1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 1, 6, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
# spi_slave

SPI slave (target) for the far end of the SPI link driven by the core's master (`spi_clk_gen` + `spi_shift`). It samples the pad signals `i_sclk`, `i_ss_n` and `i_mosi` with the system clock, deserialises MOSI into parallel words, and serialises parallel transmit words onto MISO. It supports the master's configuration set: character length, LSB/MSB-first, and independent receive and transmit clock edges. It sits between the SPI pads and a local register/FIFO client.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on each of `i_sclk`, `i_ss_n` and `i_mosi`; must be at least 2.
- `MAX_LEN`, 32: maximum character length and width of the data ports.
- `i_clk`  in  1  system clock. All logic is in this one clock domain.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_sclk`, `i_ss_n`, `i_mosi`  in  1 each  SPI pad inputs, asynchronous to `i_clk`.
- `o_miso`  out  1  serial data to the master.
- `o_miso_oe`  out  1  MISO output enable for the tristate pad.
- `i_len`  in  5  character length; 0 = 32 bits, 1..31 = that many bits.
- `i_lsb`  in  1  1 = LSB first, 0 = MSB first.
- `i_rx_negedge`  in  1  1 = sample MOSI on the falling SCLK edge, 0 = rising.
- `i_tx_negedge`  in  1  1 = change MISO on the falling SCLK edge, 0 = rising.
- `i_tx_data`  in  32  next transmit word, right-justified.
- `i_tx_valid`  in  1  `i_tx_data` is valid.
- `o_tx_ready`  out  1  transmit holding register is empty.
- `o_rx_data`  out  32  last received word, right-justified, upper bits 0.
- `o_rx_valid`  out  1  one-cycle pulse: `o_rx_data` was updated.
- `o_tx_underrun`  out  1  one-cycle pulse: a word was loaded while the holding register was empty.
- `o_busy`  out  1  FSM is in ACTIVE.

## Operation
- **Synchronisers and edge detection**
  - Each pad input passes through `SYNC_STAGES` flops; `s_sclk`, `s_ss_n` and `s_mosi` are the synchronised signals.
  - One further register on `s_sclk` and `s_ss_n` gives edge detection.
  - rx_edge = the rising or falling edge of `s_sclk`, selected by `i_rx_negedge`. tx_edge is selected the same way by `i_tx_negedge`.
- **Configuration latch:** `i_len`, `i_lsb`, `i_rx_negedge` and `i_tx_negedge` are captured on the `s_ss_n` falling edge. Changes during a frame are ignored.
- **Transmit holding register**
  - `o_tx_ready` = holding register empty.
  - A handshake (`i_tx_valid && o_tx_ready`) fills the holding register.
- **Word load** (into the tx shift register)
  - If the holding register is full, the word comes from the holding register, which is then emptied.
  - If the holding register is empty but `i_tx_valid` is high in the same cycle, `i_tx_data` bypasses directly into the shift register; no underrun.
  - Otherwise all-zeros is loaded and `o_tx_underrun` pulses.
  - After a load, `o_miso` shows the first bit: bit len-1 for MSB-first, bit 0 for LSB-first.
- **FSM states:** IDLE and ACTIVE.
  - IDLE: `o_miso_oe`=0, `o_miso`=0, bit counter=0, SCLK edges ignored.
  - IDLE → ACTIVE on the `s_ss_n` fall: configuration latched, word load performed.
  - ACTIVE → IDLE on the `s_ss_n` rise, at any point in the word.
- **ACTIVE behaviour**
  - On rx_edge, `s_mosi` is shifted into the rx shift register, the bit counter is incremented, and the `sampled` flag is set.
  - When the counter reaches len:
    - `o_rx_data` = the assembled word; the first-received bit is bit len-1 for MSB-first, bit 0 for LSB-first.
    - `o_rx_valid` pulses and the counter clears.
    - `word_done` is set.
  - On tx_edge, acting only if `sampled` is set, or if rx_edge occurs in the same cycle:
    - If `word_done` is set, perform a word load and clear `word_done`.
    - Otherwise shift to the next bit.
    - In both cases clear `sampled`.
  - A tx_edge that precedes the first sample of a word does nothing. This covers the case of an SCLK idle level opposite to the sampling edge.
- **`s_ss_n` rise mid-word (abort)**
  - The partial rx word is discarded: no `o_rx_valid`, counter cleared.
  - The word in the tx shift register is lost.
  - The holding register is untouched.
- **Back-to-back words:** with `s_ss_n` held low, words continue back-to-back; each reload happens on the tx_edge that follows the last sample of the previous word.

## Timing
- **Reset values:** `o_miso`=0, `o_miso_oe`=0, `o_tx_ready`=1, `o_rx_data`=0, `o_rx_valid`=0, `o_tx_underrun`=0, `o_busy`=0. FSM in IDLE, holding register empty. Reset is asynchronous and mid-frame safe.
- **Edge latency:** a pad edge is detected `SYNC_STAGES`+1 cycles after it reaches the pins (detect cycle N). Its effects appear in cycle N+1: `o_rx_valid`, `o_miso` change, `o_busy`/`o_miso_oe` rise, `o_tx_underrun`.
- **Pad-to-MISO latency:** at most `SYNC_STAGES`+2 cycles.
- **Clock ratio requirement:** each SCLK half-period is at least `SYNC_STAGES`+3 `i_clk` cycles. With the defaults, the SCLK period is at least 10 `i_clk` cycles.
- **`o_tx_ready`:** falls in the cycle after a handshake and rises in the cycle after a load.
- **Receive side:** no backpressure. The client must consume `o_rx_data` before the next `o_rx_valid`.

## Test plan
- **Basic MSB-first word:** `i_len`=8, MSB-first, rx rising/tx falling, SCLK idle low. Holding register = 0xA5, master sends 0x3C → `o_rx_data`=0x0000003C with one `o_rx_valid` pulse; MISO bits 1,0,1,0,0,1,0,1; no underrun.
- **Full-width LSB-first word:** `i_len`=0 (32 bits), LSB-first, both edges rising. Tx 0x80000001, rx 0xDEADBEEF → `o_rx_data`=0xDEADBEEF; MISO shows 1 first and 1 last.
- **Back-to-back words:** three 16-bit words with `i_ss_n` held low, holding register refilled after each `o_tx_ready` rise → three `o_rx_valid` pulses, correct MISO words, no underrun. Repeat with no refill → second word on MISO is 0x0000 and `o_tx_underrun` pulses once.
- **Mid-word abort:** `i_ss_n` rises after 5 of 8 bits → no `o_rx_valid`, `o_busy`/`o_miso_oe` fall within `SYNC_STAGES`+2 cycles; the next frame receives correctly.
- **Handshake corners:** `i_tx_valid` asserted in the same cycle as the `s_ss_n`-fall load with the holding register empty → bypass word transmitted, no underrun. Async reset mid-frame → all outputs at reset values and `o_tx_ready`=1.
- **Mode sweep:** all four `i_rx_negedge`/`i_tx_negedge` combinations with both SCLK idle levels, SCLK period = 10 cycles → data correct in every case.
